// File: rtl/mips_pkg.sv
// Shared types and constants for the MEM-stage memory access sequencer.
package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam logic [31:0] MEM_ERR_DATA = 32'hDEADBEEF;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Wait-cycle counter for an outstanding memory access; 'expired' flags the last allowed cycle.
module mem_timeout_ctr
#(
  parameter int TIMEOUT = 16
)
(
  input  logic clock,
  input  logic resetn,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state is written only with non-blocking assignments so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage sequencer: drives the req/ack data-memory handshake, stalls the upstream
// pipeline, bubbles MEM/WB until load data is ready, and flags timeout/misalignment.
module mem_access_ctrl
  import mips_pkg::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = MEM_ERR_DATA
)
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        mm2reg,
  input  logic        mwmem,
  input  logic [31:0] maddr,
  input  logic [31:0] mdi,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [31:0] mdo,
  output logic        stall,
  output logic        memwb_bubble,
  output logic        bus_err,
  output logic        align_err
);

  mem_state_e  state_q, state_d;
  logic [31:0] mdo_q, mdo_d;
  logic        bus_err_q, bus_err_d;
  logic        align_err_q, align_err_d;

  logic access, is_load, aligned;
  logic ctr_en, ctr_clear, expired;

  // Gating with resetn keeps req/stall low while reset is asserted even if the
  // pipeline still presents a memory instruction.
  assign access  = (mm2reg | mwmem) & resetn;
  assign is_load = mm2reg & ~mwmem;
  assign aligned = (maddr[1:0] == 2'b00);

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock     (clock),
    .resetn    (resetn),
    .clear_i   (ctr_clear),
    .en_i      (ctr_en),
    .expired_o (expired)
  );

  assign ctr_clear = (state_q != WAIT);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    mdo_d       = mdo_q;
    bus_err_d   = bus_err_q;
    align_err_d = align_err_q;
    dmem_req    = 1'b0;
    stall       = 1'b0;
    ctr_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (access) begin
          stall = 1'b1;
          if (aligned) begin
            dmem_req = 1'b1;
            state_d  = WAIT;
          end else begin
            align_err_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      WAIT: begin
        dmem_req = 1'b1;
        stall    = 1'b1;
        if (dmem_ack) begin
          if (is_load) mdo_d = dmem_rdata;
          state_d = DONE;
        end else if (expired) begin
          if (is_load) mdo_d = ERR_DATA;
          bus_err_d = 1'b1;
          state_d   = DONE;
        end else begin
          ctr_en = 1'b1;
        end
      end
      // Same instruction is still presented in DONE; it retires this edge.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      mdo_q       <= '0;
      bus_err_q   <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mdo_q       <= mdo_d;
      bus_err_q   <= bus_err_d;
      align_err_q <= align_err_d;
    end
  end

  assign memwb_bubble = stall;
  assign dmem_we      = dmem_req & mwmem;
  assign dmem_addr    = dmem_req ? word_align(maddr) : 32'h0;
  assign dmem_wdata   = dmem_we ? mdi : 32'h0;
  assign mdo          = mdo_q;
  assign bus_err      = bus_err_q;
  assign align_err    = align_err_q;

endmodule
